// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
//
// Purpose:
//   Instruction fetch stage with a small prefetch FIFO.
//   - Generates the fetch PC and issues one word request at a time on the
//     instruction memory port.
//   - Buffers the returned words as {pc, instr} entries.
//   - Presents the head entry to predecode combinationally.
//   - Raises stall_imem whenever it has nothing to deliver.
//
// Optional build macro:
//   FETCH_BYPASS_EN
//     Undefined (default): every accepted word is pushed into the FIFO and
//       appears on ir_if the cycle after its ack.
//     Defined: a word returned while the FIFO is empty is forwarded to
//       ir_if/pc_if in the ack cycle itself. If it is consumed in that cycle
//       it is not pushed.
//
// Ports:
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   stall_if     in   1 = predecode does not take the head instruction
//   redirect     in   branch/jump/trap redirect pulse
//   redirect_pc  in   new fetch target (bits [1:0] ignored)
//   imem_req     out  instruction memory request
//   imem_addr    out  word-aligned request address
//   imem_ack     in   imem_data valid for the current request
//   imem_data    in   returned instruction word
//   ir_if        out  head instruction (NOP when valid_if = 0)
//   pc_if        out  PC of ir_if (0 when valid_if = 0)
//   valid_if     out  head instruction valid
//   stall_imem   out  !valid_if
// -----------------------------------------------------------------------------
module fetch_queue #(
    parameter int              XLEN     = 64,
    parameter int              QDEPTH   = 4,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(64'h0000_0000_8000_0000)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall_if,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_data,
    output logic [31:0]     ir_if,
    output logic [XLEN-1:0] pc_if,
    output logic            valid_if,
    output logic            stall_imem
);

    localparam int          PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int          CNT_W = PTR_W + 1;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_DROP
    } state_t;

    state_t          r_state;
    logic [XLEN-1:0] r_pc;       // next fetch PC; equals r_addr while in S_REQ
    logic [XLEN-1:0] r_addr;     // address presented on imem_addr
    logic [CNT_W-1:0] r_count;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [XLEN-1:0] r_mem_pc [QDEPTH];
    logic [31:0]     r_mem_ir [QDEPTH];

    state_t           w_state_next;
    logic [XLEN-1:0]  w_pc_next;
    logic [XLEN-1:0]  w_addr_next;
    logic [CNT_W-1:0] w_count_next;
    logic [XLEN-1:0]  w_pc_inc;
    logic [XLEN-1:0]  w_redirect_pc;
    logic             w_head_valid;
    logic             w_bypass;
    logic             w_push;
    logic             w_pop_fifo;

    assign w_head_valid  = (r_count != '0);
    assign w_pc_inc      = r_pc + XLEN'(4);
    // Masking rather than slicing keeps every redirect_pc bit in use.
    assign w_redirect_pc = redirect_pc & ~XLEN'(3);

`ifdef FETCH_BYPASS_EN
    // Forward the returning word when nothing older is queued. Words
    // returned in S_DROP or alongside a redirect are stale and never forwarded.
    assign w_bypass = !w_head_valid && (r_state == S_REQ) && imem_ack && !redirect;
`else
    assign w_bypass = 1'b0;
`endif

    // A forwarded word that is consumed in its ack cycle never enters the FIFO.
    assign w_push     = !redirect && (r_state == S_REQ) && imem_ack && !(w_bypass && !stall_if);
    assign w_pop_fifo = w_head_valid && !stall_if && !redirect;

    always_comb begin
        w_count_next = r_count;
        if (redirect) begin
            w_count_next = '0;
        end else begin
            w_count_next = r_count + CNT_W'(w_push) - CNT_W'(w_pop_fifo);
        end
    end

    // Next-state logic. Credit is "count + outstanding < QDEPTH". Each
    // transition into S_REQ loads r_addr with the PC to be requested.
    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_addr_next  = r_addr;
        if (redirect) begin
            w_pc_next = w_redirect_pc;
            if ((r_state != S_IDLE) && !imem_ack) begin
                // Keep the old request on the bus until its ack drains it.
                w_state_next = S_DROP;
            end else begin
                // The FIFO is flushed, so credit is always available here.
                w_state_next = S_REQ;
                w_addr_next  = w_redirect_pc;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (r_count < CNT_W'(QDEPTH)) begin
                        w_state_next = S_REQ;
                        w_addr_next  = r_pc;
                    end
                end
                S_REQ: begin
                    if (imem_ack) begin
                        w_pc_next = w_pc_inc;
                        if (w_count_next < CNT_W'(QDEPTH)) begin
                            w_addr_next = w_pc_inc;
                        end else begin
                            w_state_next = S_IDLE;
                        end
                    end
                end
                S_DROP: begin
                    if (imem_ack) begin
                        if (r_count < CNT_W'(QDEPTH)) begin
                            w_state_next = S_REQ;
                            w_addr_next  = r_pc;
                        end else begin
                            w_state_next = S_IDLE;
                        end
                    end
                end
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_pc     <= RESET_PC;
            r_addr   <= RESET_PC;
            r_count  <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            r_addr  <= w_addr_next;
            r_count <= w_count_next;
            if (redirect) begin
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
            end else begin
                if (w_pop_fifo) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                if (w_push)     r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
        end
    end

    // FIFO storage. It needs no reset because r_count gates every read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_pc[r_wr_ptr] <= r_addr;
            r_mem_ir[r_wr_ptr] <= imem_data;
        end
    end

    assign imem_req   = (r_state != S_IDLE);
    assign imem_addr  = r_addr;
    assign valid_if   = w_head_valid || w_bypass;
    assign stall_imem = !valid_if;

    always_comb begin
        ir_if = NOP;
        pc_if = '0;
        if (w_head_valid) begin
            ir_if = r_mem_ir[r_rd_ptr];
            pc_if = r_mem_pc[r_rd_ptr];
        end else if (w_bypass) begin
            ir_if = imem_data;
            pc_if = r_addr;
        end
    end

endmodule
